// File: rtl/load_store_unit_if.sv
// Core-request and DataMemory signals of the load/store unit, bundled as one port.
// The slave modport is the unit itself; master is the core/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core requests into word-only DataMemory
// cycles, with read-modify-write for sub-word stores and sign/zero-extended loads.
module load_store_unit #(
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [2:0]         dbgState
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, RESP} state_t;

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a one-cycle pulse in RESP.
  state_t        state;
  logic [AW+1:0] addrQ;
  logic [1:0]    sizeQ;
  logic          unsignedQ;
  logic [31:0]   wdataQ;
  logic [31:0]   respRdataQ;
  logic          respErrQ;
  logic          reqErr;

  function automatic logic [31:0] extractLane(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = '0;
    case (size)
      2'b00:   res = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01: begin
        sh  = off[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
        res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      2'b10:   res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [31:0] data,
                                            input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    logic [31:0] ins;
    if (size == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      ins  = {24'b0, data[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      ins  = {16'b0, data[15:0]} << {off[1], 4'b0000};
    end
    return (word & ~mask) | ins;
  endfunction

  always_comb begin
    reqErr = 1'b0;
    if (bus.req_size == 2'b11)                               reqErr = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])            reqErr = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) reqErr = 1'b1;
    if ({1'b0, bus.req_addr} >= ADDR_LIMIT)                  reqErr = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addrQ      <= '0;
      sizeQ      <= '0;
      unsignedQ  <= 1'b0;
      wdataQ     <= '0;
      respRdataQ <= '0;
      respErrQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addrQ      <= bus.req_addr[AW+1:0];
          sizeQ      <= bus.req_size;
          unsignedQ  <= bus.req_unsigned;
          wdataQ     <= bus.req_wdata;
          respRdataQ <= '0;
          respErrQ   <= reqErr;
          if (reqErr)                    state <= RESP;
          else if (!bus.req_write)       state <= LD;
          else if (bus.req_size == 2'b10) state <= WR;
          else                           state <= RMW_RD;
        end
        LD: begin
          respRdataQ <= extractLane(bus.mem_read_data, addrQ[1:0], sizeQ, unsignedQ);
          state      <= RESP;
        end
        // The merged word replaces the store data so WR only ever writes wdataQ.
        RMW_RD: begin
          wdataQ <= mergeLane(bus.mem_read_data, wdataQ, addrQ[1:0], sizeQ);
          state  <= WR;
        end
        WR:   state <= RESP;
        RESP: begin
          respErrQ <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes come straight from the state register so reset kills them at once.
  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_err       = respErrQ;
  assign bus.resp_rdata     = respRdataQ;
  assign bus.mem_read       = (state == LD) || (state == RMW_RD);
  assign bus.mem_write      = (state == WR);
  assign bus.mem_address    = (state == LD || state == RMW_RD || state == WR) ?
                              32'(addrQ[AW+1:2]) : 32'b0;
  assign bus.mem_write_data = (state == WR) ? wdataQ : 32'b0;
  assign dbgState           = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide DataMemory model.
module tb_load_store_unit;
  logic        clk;
  logic        rst_n;
  logic [2:0]  dbg_state;
  logic [31:0] mem [0:1023];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          rd_cnt, wr_cnt;
  logic [31:0] wr_addr, wr_data;

  load_store_unit_if bus ();

  load_store_unit #(.DEPTH(1024)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbgState (dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[9:0]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[9:0]] <= bus.mem_write_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: issue one request, then monitor until resp_valid
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_rd, input int exp_wr);
    int lat;
    int waited;
    bit got;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check_eq({tag, "/ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    bus.req_write    = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    exp_q.push_back(exp_rdata);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h5A5A_5A5A;
    rd_cnt = 0;
    wr_cnt = 0;
    lat    = 0;
    got    = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.mem_read) rd_cnt++;
      if (bus.mem_write) begin
        wr_cnt++;
        wr_addr = bus.mem_address;
        wr_data = bus.mem_write_data;
      end
      if (bus.resp_valid) got = 1'b1;
    end
    if (!got) begin
      check_eq({tag, "/resp_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "/rdata"}, bus.resp_rdata, exp_q.pop_front());
    check_eq({tag, "/err"}, 32'(bus.resp_err), 32'(exp_err));
    check_eq({tag, "/ready_in_resp"}, 32'(bus.req_ready), 32'd0);
    check_eq({tag, "/mem_reads"}, 32'(rd_cnt), 32'(exp_rd));
    check_eq({tag, "/mem_writes"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  initial begin
    int acc, resp, bad;
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst/resp_err", 32'(bus.resp_err), 32'd0);
    check_eq("rst/resp_rdata", bus.resp_rdata, 32'd0);
    check_eq("rst/mem_read", 32'(bus.mem_read), 32'd0);
    check_eq("rst/mem_write", 32'(bus.mem_write), 32'd0);
    check_eq("rst/mem_address", bus.mem_address, 32'd0);
    check_eq("rst/mem_write_data", bus.mem_write_data, 32'd0);

    do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1);
    check_eq("sw_10/wr_addr", wr_addr, 32'd4);
    check_eq("sw_10/wr_data", wr_data, 32'hDEAD_BEEF);
    do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0);

    do_req("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56A5, 32'h0, 1'b0, 3, 1, 1);
    check_eq("sb_11/wr_data", wr_data, 32'hDEAD_A5EF);
    check_eq("sb_11/mem_word", mem[4], 32'hDEAD_A5EF);

    do_req("lb_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, 1, 0);
    do_req("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_00A5, 1'b0, 2, 1, 0);
    do_req("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 1, 0);
    do_req("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 2, 1, 0);
    do_req("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, 1, 0);
    do_req("lb_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 2, 1, 0);
    do_req("lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_A5EF, 1'b0, 2, 1, 0);

    do_req("sh_12", 1'b1, 2'b01, 1'b1, 32'h12, 32'hFFFF_1234, 32'h0, 1'b0, 3, 1, 1);
    do_req("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_A5EF, 1'b0, 2, 1, 0);
    do_req("lhu_12b", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_1234, 1'b0, 2, 1, 0);

    // top word of memory is in range; the limit itself is not
    do_req("sw_ffc", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0, 1);
    check_eq("sw_ffc/wr_addr", wr_addr, 32'd1023);
    do_req("lw_ffc", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1, 0);

    do_req("lh_13_err", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sw_2002_err", 1'b1, 2'b10, 1'b0, 32'h2002, 32'h1111_1111, 32'h0, 1'b1, 1, 0, 0);
    do_req("lw_1000_err", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sb_1000_err", 1'b1, 2'b00, 1'b0, 32'h1000, 32'h77, 32'h0, 1'b1, 1, 0, 0);
    do_req("sw_12_err", 1'b1, 2'b10, 1'b0, 32'h12, 32'h2222_2222, 32'h0, 1'b1, 1, 0, 0);
    do_req("size11_err", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("lw_after_err", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_A5EF, 1'b0, 2, 1, 0);

    // reset dropped during WR of a sub-word store
    do_req("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 2, 0, 1);
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h0000_00FF;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstwr/rmw_read", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    check_eq("rstwr/in_wr", 32'(bus.mem_write), 32'd1);
    check_eq("rstwr/merged", bus.mem_write_data, 32'h1122_33FF);
    rst_n = 1'b0;
    #1;
    check_eq("rstwr/mem_write_drop", 32'(bus.mem_write), 32'd0);
    check_eq("rstwr/req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rstwr/state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rstwr/mem_word", mem[8], 32'h1122_3344);
    do_req("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 2, 1, 0);

    // back-to-back: req_valid held high over three transactions
    @(negedge clk);
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_valid    = 1'b1;
    acc  = 0;
    resp = 0;
    bad  = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.resp_valid) begin
        resp++;
        if (bus.req_ready) bad++;
        check_eq("b2b/rdata", bus.resp_rdata, 32'h1234_A5EF);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check_eq("b2b/accepts", 32'(acc), 32'd3);
    check_eq("b2b/responses", 32'(resp), 32'd3);
    check_eq("b2b/ready_with_resp", 32'(bad), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("b2b/idle_ready", 32'(bus.req_ready), 32'd1);
    check_eq("b2b/exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
